// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and access-size helper for the data memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access; 0 marks an encoding with no defined size.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - load extractor: picks the low 1/2/4 raw bytes and sign- or zero-extends them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  always_comb begin
    data = 32'd0;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_W:    data = raw;
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked byte-addressed data memory with fixed wait states.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of performing them byte-wise.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            lat_write;
  logic [AW-1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [2:0]      lat_funct3;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            in_idle;
  logic            accept;
  logic            do_access;
  logic            a_write;
  logic [AW-1:0]   a_addr;
  logic [31:0]     a_wdata;
  logic [2:0]      a_funct3;
  logic [2:0]      a_size;
  logic            a_err;
  logic [31:0]     raw;
  logic [31:0]     load_data;
  logic            unused_addr;

  assign unused_addr = ^req_addr[31:AW];
  assign in_idle     = (state == IDLE);
  assign accept      = in_idle && req_valid;

  // With zero wait states the access happens on the accept edge, so operands come straight from the request.
  assign a_write  = in_idle ? req_write          : lat_write;
  assign a_addr   = in_idle ? req_addr[AW-1:0]   : lat_addr;
  assign a_wdata  = in_idle ? req_wdata          : lat_wdata;
  assign a_funct3 = in_idle ? req_funct3         : lat_funct3;

  assign do_access = !rst && ((accept && (WAIT_CYCLES == 0)) || (state == WAIT && cnt == 4'd0));

  always_comb begin
    a_size = size_bytes(a_funct3);
    a_err  = (a_size == 3'd0) || (a_write && a_funct3[2]);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((a_size == 3'd2 && a_addr[0]) || (a_size == 3'd4 && a_addr[1:0] != 2'b00))
      a_err = 1'b1;
`else
    a_err = a_err;
`endif
  end

  assign raw = {mem[a_addr + AW'(3)], mem[a_addr + AW'(2)], mem[a_addr + AW'(1)], mem[a_addr]};

  dmem_lane_align u_align (
    .raw    (raw),
    .funct3 (a_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      lat_funct3 <= 3'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= CNT_INIT;
        lat_write  <= req_write;
        lat_addr   <= req_addr[AW-1:0];
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_rdata <= (a_write || a_err) ? 32'd0 : load_data;
        rsp_err   <= a_err;
      end
    end
  end

  // RAM is deliberately outside the reset domain; byte indices wrap at the array size.
  always_ff @(posedge clk) begin
    if (do_access && a_write && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < a_size) mem[a_addr + AW'(i)] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 4096;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [2:0]  z_req_funct3 = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) u_zero (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_funct3(z_req_funct3), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: size/sign from funct3, little-endian bytes, modulo-DEPTH wrap.
  task automatic model(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rd, output bit err);
    int sz = 0;
    bit sgn = 0;
    bit ok;
    logic [31:0] val = 0;
    case (f3)
      3'b000: begin sz = 1; sgn = 1; end
      3'b001: begin sz = 2; sgn = 1; end
      3'b010: sz = 4;
      3'b100: sz = 1;
      3'b101: sz = 2;
      default: sz = 0;
    endcase
    ok = (sz != 0) && !(w && (f3 == 3'b100 || f3 == 3'b101));
`ifdef DMEM_MISALIGN_ERR_EN
    if (ok && sz > 1 && (addr % sz) != 0) ok = 0;
`endif
    err = !ok;
    rd = 0;
    if (ok) begin
      for (int i = 0; i < sz; i++) begin
        if (w) ref_mem[(addr + i) % DEPTH] = 8'(wdata >> (8 * i));
        else   val = val | (32'(ref_mem[(addr + i) % DEPTH]) << (8 * i));
      end
      if (!w && sgn && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
      rd = val;
    end
  endtask

  task automatic op(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [2:0] f3, input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit exp_err;
    int lat;
    model(w, addr, wdata, f3, exp_rd, exp_err);
    @(negedge clk);
    req_write = w; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, WC + 1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    rd = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_req_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_z_req_ready", z_req_ready, 1);
    chk("rst_z_rsp_valid", z_rsp_valid, 0);

    for (int i = 0; i < 256; i += 4) op(1, i, 0, F3_W, 0, rd);
    for (int i = 12'hFF0; i < DEPTH; i += 4) op(1, i, 0, F3_W, 0, rd);

    op(1, 32'h10, 32'hDEADBEEF, F3_W, 0, rd);
    op(0, 32'h10, 0, F3_W, 0, rd);  chk("lw_10", rd, 32'hDEADBEEF);
    op(0, 32'h13, 0, F3_B, 0, rd);  chk("lb_13", rd, 32'hFFFFFFDE);
    op(0, 32'h13, 0, F3_BU, 0, rd); chk("lbu_13", rd, 32'h000000DE);
    op(0, 32'h12, 0, F3_H, 0, rd);  chk("lh_12", rd, 32'hFFFFDEAD);
    op(0, 32'h10, 0, F3_HU, 0, rd); chk("lhu_10", rd, 32'h0000BEEF);

    op(1, 32'h20, 32'h11223344, F3_B, 0, rd);
    op(0, 32'h20, 0, F3_W, 5, rd);  chk("lw_20_bp", rd, 32'h00000044);

`ifdef DMEM_MISALIGN_ERR_EN
    op(1, 32'h100, 32'h01020304, F3_W, 0, rd);
    op(0, 32'h102, 0, F3_W, 0, rd); chk("lw_102_rdata", rd, 0);
    op(1, 32'h101, 32'hFFFFFFFF, F3_W, 0, rd);
    op(0, 32'h100, 0, F3_W, 0, rd); chk("lw_100_unchanged", rd, 32'h01020304);
`else
    op(1, 32'hFFE, 32'hAABBCCDD, F3_W, 0, rd);
    op(0, 32'hFFE, 0, F3_BU, 0, rd); chk("wrap_ffe", rd, 32'hDD);
    op(0, 32'hFFF, 0, F3_BU, 0, rd); chk("wrap_fff", rd, 32'hCC);
    op(0, 32'h000, 0, F3_BU, 0, rd); chk("wrap_000", rd, 32'hBB);
    op(0, 32'h001, 0, F3_BU, 0, rd); chk("wrap_001", rd, 32'hAA);
`endif

    op(0, 32'h10, 0, 3'b011, 0, rd); chk("f3_011_rdata", rd, 0);
    op(1, 32'h10, 32'h55555555, F3_HU, 1, rd);
    op(0, 32'h10, 0, F3_W, 0, rd);   chk("hu_store_nowrite", rd, 32'hDEADBEEF);

    op(1, 32'h40, 32'h12345678, F3_W, 0, rd);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_funct3 = F3_W; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    op(0, 32'h40, 0, F3_W, 0, rd);   chk("abort_old_value", rd, 32'h12345678);

    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(12'hFF0, 12'hFFF));
      a = a | ($urandom & 32'hFFFF_F000);
      op(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), rd);
    end

    z_rsp_ready = 1'b1;
    z_req_write = 1'b1; z_req_funct3 = F3_W; z_req_addr = 32'h80; z_req_wdata = $urandom;
    @(negedge clk);
    z_req_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("z_rsp_valid", z_rsp_valid, 32'(i % 2));
      chk("z_req_ready", z_req_ready, 32'((i % 2) == 0));
      if (i % 2 == 1) begin
        chk("z_rsp_err", z_rsp_err, 0);
        chk("z_rsp_rdata", z_rsp_rdata, 0);
      end else begin
        z_req_wdata = $urandom;
      end
    end
    z_req_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
